// File: rtl/block_sync_pkg.sv
// block_sync_pkg: shared Interlaken lane definitions (lock FSM states, sync header codes).
package block_sync_pkg;

    typedef enum logic [1:0] {ST_HUNT, ST_SLIP_WAIT, ST_LOCKED} state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic is_valid_sh(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_sync.sv
// block_sync: 64b/67b word-lock; slips the gearbox until a full window of valid sync
// headers is seen, then drops lock on too many header errors within one window.
module block_sync
    import block_sync_pkg::*;
#(
    parameter int RX_DATA_WIDTH  = 64,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET,
    input  logic [RX_DATA_WIDTH-1:0] DATA_IN,
    input  logic [1:0]               HEADER_IN,
    input  logic                     DATA_IN_VALID,
    output logic [RX_DATA_WIDTH-1:0] DATA_OUT,
    output logic [1:0]               HEADER_OUT,
    output logic                     DATA_OUT_VALID,
    output logic                     RX_SLIP,
    output logic                     BLOCK_LOCK
);

    localparam int SW = $clog2(SH_CNT_MAX) + 1;
    localparam int IW = $clog2(SH_INVALID_MAX) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;

    state_t                   state_q, state_d;
    logic [SW-1:0]            sh_cnt_q, sh_cnt_d;
    logic [IW-1:0]            inv_cnt_q, inv_cnt_d;
    logic [WW-1:0]            wait_cnt_q, wait_cnt_d;
    logic                     slip_d, sh_ok, win_end;
    logic [RX_DATA_WIDTH-1:0] data_q;
    logic [1:0]               header_q;
    logic                     valid_q, slip_q, lock_q;

    assign sh_ok   = is_valid_sh(HEADER_IN);
    assign win_end = sh_cnt_q == SW'(SH_CNT_MAX - 1);

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_d     = 1'b0;
        unique case (state_q)
            ST_HUNT: if (DATA_IN_VALID) begin
                if (!sh_ok) begin
                    slip_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_SLIP_WAIT;
                end else if (win_end) begin
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                    state_d   = ST_LOCKED;
                end else begin
                    sh_cnt_d = sh_cnt_q + SW'(1);
                end
            end
            ST_SLIP_WAIT: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (wait_cnt_q == WW'(SLIP_WAIT - 1)) begin
                    sh_cnt_d = '0;
                    state_d  = ST_HUNT;
                end
            end
            ST_LOCKED: if (DATA_IN_VALID) begin
                // the error limit wins over the window-end clear on the same word
                if (!sh_ok && inv_cnt_q == IW'(SH_INVALID_MAX - 1)) begin
                    slip_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_SLIP_WAIT;
                end else if (win_end) begin
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                end else begin
                    sh_cnt_d  = sh_cnt_q + SW'(1);
                    inv_cnt_d = inv_cnt_q + IW'(!sh_ok);
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q    <= ST_HUNT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            data_q     <= '0;
            header_q   <= '0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= DATA_IN;
            header_q   <= HEADER_IN;
            valid_q    <= DATA_IN_VALID && (state_d == ST_LOCKED);
            slip_q     <= slip_d;
            lock_q     <= state_d == ST_LOCKED;
        end
    end

    assign DATA_OUT       = data_q;
    assign HEADER_OUT     = header_q;
    assign DATA_OUT_VALID = valid_q;
    assign RX_SLIP        = slip_q;
    assign BLOCK_LOCK     = lock_q;

endmodule
